bit_serial_subtractor: RTL and testbench
========================================

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH bits: minuend.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in.
REQ-008 SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-010 SHALL have port diff, output, WIDTH bits: registered difference.
REQ-011 SHALL have port bout, output, 1 bit: registered final borrow-out.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start SHALL be ignored in RUN, with operands unchanged and no restart.
REQ-014 SHALL, on an accepted start at edge k, capture a, b and bin into internal registers, clear the bit counter, and enter RUN; busy SHALL be 1 from edge k.
REQ-015 SHALL process one bit per RUN cycle, LSB first, using a full-subtractor cell: d = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 SHALL hold the borrow br in a flop; br SHALL be initialised from the captured bin.
REQ-017 SHALL shift each d into a result shift register from the MSB side, so that after WIDTH steps bit i holds d_i.
REQ-018 SHALL use a bit counter of width $clog2(WIDTH)+1 that SHALL stop at WIDTH and never wrap.
REQ-019 SHALL stay in RUN for exactly WIDTH cycles; at edge k+WIDTH it SHALL load diff and bout, set done=1, set busy=0, and enter DONE.
REQ-020 SHALL give a latency from start edge to done edge of exactly WIDTH clock cycles.
REQ-021 SHALL hold done high for exactly one cycle.
REQ-022 SHALL, from DONE, return to IDLE on the next edge if start=0, or enter RUN with the new operands if start=1 (back-to-back operation, no idle gap).
REQ-023 SHALL hold diff and bout stable from the done pulse until the next done pulse, and SHALL NOT change them during RUN.
REQ-024 SHALL produce a result equal to (a - b - bin) mod 2^WIDTH, with bout=1 iff a < b + bin (unsigned comparison).
REQ-025 SHALL sample a, b and bin only at the accepting edge; input changes during RUN SHALL have no effect.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, done=0, diff=0, bout=0, the counter to 0 and br to 0, independent of clk.
REQ-027 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse; the first start after reset release SHALL begin a fresh subtraction.
REQ-028 SHALL treat start as not accepted on the first rising edge at which rst_n is low.

Verification (WIDTH=4)
REQ-029 SHALL verify a=5, b=3, bin=0, start pulsed -> done exactly 4 cycles later, diff=2, bout=0.
REQ-030 SHALL verify a=3, b=5, bin=0 -> diff=14, bout=1; and a=0, b=0, bin=1 -> diff=15, bout=1.
REQ-031 SHALL verify a=15, b=15, bin=0 -> diff=0, bout=0; and start re-pulsed in the DONE cycle with a=9, b=1 -> next done 4 cycles later, diff=8, no idle gap.
REQ-032 SHALL verify that start=1 with new operands during RUN is ignored and the original result is delivered unchanged.
REQ-033 SHALL verify that rst_n pulled low at RUN cycle 2 sets all outputs to 0 asynchronously with no done pulse, and that a subsequent start with a=7, b=2 gives diff=5, bout=0.
REQ-034 SHALL verify all 512 combinations of a, b and bin for WIDTH=4 against the REQ-024 reference model.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor
//   Computes (a - b - bin) mod 2^WIDTH one bit per clock, LSB first. A single
//   full-subtractor cell and a borrow flop are reused for every bit position.
//   The latency from the start edge to the done edge is WIDTH clock cycles.
//
// Parameters
//   WIDTH : operand/result width in bits (2..32)
//
// Ports
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   start in   request a subtraction (accepted in IDLE or DONE only)
//   a     in   minuend   [WIDTH-1:0]
//   b     in   subtrahend [WIDTH-1:0]
//   bin   in   borrow-in
//   busy  out  high while a subtraction is in progress
//   done  out  one-cycle pulse: diff/bout hold a fresh result
//   diff  out  registered difference [WIDTH-1:0]
//   bout  out  registered final borrow-out
// -----------------------------------------------------------------------------
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_sr;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sr_next;

  // Full-subtractor cell on the current LSB of the shifting operands.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // New difference bit enters from the MSB side. The partial-result register
  // is one bit short because on the final step the full word goes straight
  // into r_diff, so the bit that would fall off the bottom is never needed.
  assign w_sr_next = {w_d, r_sr};

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_br    <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_sr    <= {(WIDTH-1){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= {WIDTH{1'b0}};
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_a  <= {1'b0, r_a[WIDTH-1:1]};
          r_b  <= {1'b0, r_b[WIDTH-1:1]};
          r_br <= w_br_next;
          r_sr <= w_sr_next[WIDTH-1:1];
          // Counter saturates at WIDTH instead of wrapping.
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= r_cnt;
          end
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_diff  <= w_sr_next;
            r_bout  <= w_br_next;
          end else begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bit_serial_subtractor (WIDTH=4).
// A transaction-level model predicts busy/done/diff/bout every cycle from plain
// arithmetic; directed cases pin both the DUT and the model to literal values.
// -----------------------------------------------------------------------------
module tb_bit_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_vec = 0;
  int n_err = 0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: a start seen while nothing is pending
  // launches a job whose result appears exactly W edges later.
  logic         m_busy, m_done, m_bout, m_res_b;
  logic [W-1:0] m_diff, m_res;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_diff <= '0; m_bout <= 1'b0;
      m_res  <= '0;   m_res_b <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (m_left == 1) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_diff <= m_res; m_bout <= m_res_b;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_left  <= W;
        m_busy  <= 1'b1;
        m_res   <= W'((int'(a) - int'(b) - int'(bin)) & ((1 << W) - 1));
        m_res_b <= (int'(a) < int'(b) + int'(bin));
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    n_vec++;
    if ({busy, done, diff, bout} !== {m_busy, m_done, m_diff, m_bout}) begin
      n_err++;
      $display("FAIL model t=%0t busy %b/%b done %b/%b diff %0d/%0d bout %b/%b (got/exp)",
               $time, busy, m_busy, done, m_done, diff, m_diff, bout, m_bout);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply operands with start for exactly one rising edge (edge k).
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after edge k until done; optionally scramble operands meanwhile.
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: done not seen, got lat %0d, expected 4", lat);
    end
  endtask

  int lat;
  int ea, eb, ebin;

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3 - 0 = 2
    launch(4'd5, 4'd3, 1'b0);
    check("busy_at_k", busy, 1);
    wait_done(1'b0, lat);
    check("lat_5_3", lat, 4);
    check("diff_5_3", diff, 2);
    check("bout_5_3", bout, 0);
    check("model_5_3", m_diff, 2);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("diff_hold", diff, 2);
    @(negedge clk);

    launch(4'd3, 4'd5, 1'b0);
    wait_done(1'b0, lat);
    check("diff_3_5", diff, 14);
    check("bout_3_5", bout, 1);
    check("model_b_3_5", m_bout, 1);
    @(negedge clk);

    launch(4'd0, 4'd0, 1'b1);
    wait_done(1'b0, lat);
    check("diff_0_0_1", diff, 15);
    check("bout_0_0_1", bout, 1);
    @(negedge clk);

    // Back-to-back: restart in the DONE cycle.
    launch(4'd15, 4'd15, 1'b0);
    wait_done(1'b0, lat);
    check("diff_15_15", diff, 0);
    check("bout_15_15", bout, 0);
    launch(4'd9, 4'd1, 1'b0);
    check("b2b_busy_no_gap", busy, 1);
    wait_done(1'b0, lat);
    check("b2b_lat", lat, 4);
    check("diff_9_1", diff, 8);
    check("bout_9_1", bout, 0);
    @(negedge clk);

    // start with new operands during RUN is ignored.
    launch(4'd5, 4'd3, 1'b0);
    a = 4'd15; b = 4'd0; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, lat);
    check("ignore_lat", lat + 2, 4);
    check("ignore_diff", diff, 2);
    check("ignore_bout", bout, 0);
    @(negedge clk);

    // Reset mid-run: outputs drop asynchronously, start during reset ignored.
    launch(4'd5, 4'd3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0; start = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_bout", bout, 0);
    @(posedge clk); #1;
    check("start_in_reset", busy, 0);
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_rst", done, 0);
    launch(4'd7, 4'd2, 1'b0);
    wait_done(1'b0, lat);
    check("diff_7_2", diff, 5);
    check("bout_7_2", bout, 0);
    @(negedge clk);

    // All 512 operand combinations, random gaps/back-to-back and input noise.
    for (int i = 0; i < 512; i++) begin
      ea = (i >> 5) & 15; eb = (i >> 1) & 15; ebin = i & 1;
      launch(W'(ea), W'(eb), 1'(ebin));
      wait_done(1'b1, lat);
      check("exh_lat", lat, 4);
      check("exh_diff", diff, (ea - eb - ebin) & 15);
      check("exh_bout", bout, (ea < eb + ebin) ? 1 : 0);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
